// File: rtl/gfx_pkg.sv
// Shared definitions for the VGA graphics processor load path.
package gfx_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Longest ROM read latency the latency counter supports
    localparam int unsigned MAX_ROM_LATENCY = 4;
    localparam int unsigned LAT_W           = $clog2(MAX_ROM_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_FETCH = ST_FETCH,
        S_WRITE = ST_WRITE,
        S_DONE  = ST_DONE
    } copy_state_e;

endpackage

// File: rtl/rom_ram_copy_ctrl_if.sv
// ROM read port and shared RAM write port seen by the copy controller.
interface rom_ram_copy_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic                  ram_req;
    logic                  ram_gnt;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;

    modport master (
        output rom_addr, ram_req, ram_we, ram_addr, ram_wdata,
        input  rom_data, ram_gnt
    );

    modport slave (
        input  rom_addr, ram_req, ram_we, ram_addr, ram_wdata,
        output rom_data, ram_gnt
    );
endinterface

// File: rtl/copy_index_counter.sv
// Word index for the copy, with terminal compare against the latched length.
module copy_index_counter #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] len,
    output logic [ADDR_WIDTH-1:0] idx,
    output logic                  last
);

    // Index register: clear wins over enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (en) begin
            idx <= ADDR_WIDTH'(idx + ADDR_WIDTH'(1));
        end
    end

    assign last = (idx == ADDR_WIDTH'(len - ADDR_WIDTH'(1)));

endmodule

// File: rtl/rom_ram_copy_ctrl.sv
// ROM-to-RAM block copy sequencer: fetch a word, wait out ROM latency,
// write it through the arbitrated RAM port, repeat for len words.
module rom_ram_copy_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ROM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] src_base,
    input  logic [ADDR_WIDTH-1:0] dst_base,
    input  logic [ADDR_WIDTH-1:0] len,
    output logic                  busy,
    output logic                  done,
    rom_ram_copy_ctrl_if.master   bus
);
    import gfx_pkg::*;

    copy_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, dst_q, len_q;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  last;
    logic [LAT_W-1:0]      lat_q;
    logic                  accept, fetch_end, commit;
    logic                  fetch_entry;

    copy_index_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_idx (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .en    (commit & ~last),
        .len   (len_q),
        .idx   (idx),
        .last  (last)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-cycle strobes; abort overrides every transition
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        fetch_end = 1'b0;
        commit    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = (len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (lat_q == LAT_W'(ROM_LATENCY - 1)) begin
                    fetch_end = 1'b1;
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                if (bus.ram_gnt) begin
                    commit  = 1'b1;
                    state_d = last ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort) begin
            state_d   = S_IDLE;
            accept    = 1'b0;
            fetch_end = 1'b0;
            commit    = 1'b0;
        end
    end

    assign fetch_entry = (state_d == S_FETCH) && (state_q != S_FETCH);

    // Registered outputs, latched copy parameters, latency counter, datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            bus.ram_req   <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.rom_addr  <= '0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            src_q         <= '0;
            dst_q         <= '0;
            len_q         <= '0;
            lat_q         <= '0;
        end else begin
            busy        <= (state_d != S_IDLE);
            done        <= (state_d == S_DONE);
            bus.ram_req <= (state_d == S_WRITE);
            bus.ram_we  <= (state_d == S_WRITE);

            if (accept) begin
                src_q <= src_base;
                dst_q <= dst_base;
                len_q <= len;
            end

            // First word addresses src_base directly; later words use idx+1
            // because the counter advances on the same edge.
            if (fetch_entry) begin
                lat_q        <= '0;
                bus.rom_addr <= accept ? src_base
                                       : ADDR_WIDTH'(src_q + idx + ADDR_WIDTH'(1));
            end else if (state_q == S_FETCH) begin
                lat_q <= LAT_W'(lat_q + LAT_W'(1));
            end

            if (fetch_end) begin
                bus.ram_wdata <= bus.rom_data;
                bus.ram_addr  <= ADDR_WIDTH'(dst_q + idx);
            end
        end
    end

endmodule
